// File: rtl/axilite_master_engine.sv
// AXI-Lite master that turns single-cycle backend read/write commands into complete
// AXI-Lite transactions, with response error reporting and a per-state timeout.
module axilite_master_engine #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  output logic                axi_awvalid,
  output logic [ADDR_W-1:0]   axi_awaddr,
  input  logic                axi_awready,
  output logic                axi_wvalid,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wready,
  input  logic                axi_bvalid,
  input  logic [1:0]          axi_bresp,
  output logic                axi_bready,
  output logic                axi_arvalid,
  output logic [ADDR_W-1:0]   axi_araddr,
  input  logic                axi_arready,
  input  logic                axi_rvalid,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  output logic                axi_rready,
  input  logic                bk_wstart,
  input  logic [ADDR_W-1:0]   bk_waddr,
  input  logic [DATA_W-1:0]   bk_wdata,
  input  logic [DATA_W/8-1:0] bk_wstrb,
  output logic                bk_wdone,
  output logic                bk_werr,
  input  logic                bk_rstart,
  input  logic [ADDR_W-1:0]   bk_raddr,
  output logic [DATA_W-1:0]   bk_rdata,
  output logic                bk_rdone,
  output logic                bk_rerr,
  output logic                bk_busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fin_q, fin_d;
  logic                err_q, err_d;
  logic                awValid_q, awValid_d;
  logic                wValid_q, wValid_d;
  logic                bReady_q, bReady_d;
  logic                arValid_q, arValid_d;
  logic                rReady_q, rReady_d;
  logic [ADDR_W-1:0]   awAddr_q, awAddr_d;
  logic [DATA_W-1:0]   wData_q, wData_d;
  logic [STRB_W-1:0]   wStrb_q, wStrb_d;
  logic [ADDR_W-1:0]   arAddr_q, arAddr_d;
  logic                rdQueued_q, rdQueued_d;
  logic [DATA_W-1:0]   rCap_q, rCap_d;
  logic [DATA_W-1:0]   rData_q, rData_d;
  logic                wDone_q, wDone_d;
  logic                wErr_q, wErr_d;
  logic                rDone_q, rDone_d;
  logic                rErr_q, rErr_d;
  logic                busy_q, busy_d;
  logic                timeoutHit;
  logic                awPending;
  logic                wPending;

  assign timeoutHit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign awPending  = awValid_q && !axi_awready;
  assign wPending   = wValid_q && !axi_wready;

  // fin_q marks the one cycle between the final handshake (or abort) and the done pulse
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fin_d      = fin_q;
    err_d      = err_q;
    awValid_d  = awValid_q;
    wValid_d   = wValid_q;
    bReady_d   = bReady_q;
    arValid_d  = arValid_q;
    rReady_d   = rReady_q;
    awAddr_d   = awAddr_q;
    wData_d    = wData_q;
    wStrb_d    = wStrb_q;
    arAddr_d   = arAddr_q;
    rdQueued_d = rdQueued_q;
    rCap_d     = rCap_q;
    rData_d    = rData_q;
    wDone_d    = 1'b0;
    wErr_d     = 1'b0;
    rDone_d    = 1'b0;
    rErr_d     = 1'b0;

    if (fin_q) begin
      fin_d   = 1'b0;
      state_d = IDLE;
      if (state_q == WR_REQ || state_q == WR_RESP) begin
        wDone_d = 1'b1;
        wErr_d  = err_q;
      end else begin
        rDone_d = 1'b1;
        rErr_d  = err_q;
        rData_d = rCap_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (rdQueued_q) begin
            state_d    = RD_REQ;
            arValid_d  = 1'b1;
            rdQueued_d = 1'b0;
          end else if (!busy_q) begin
            if (bk_wstart) begin
              state_d   = WR_REQ;
              awValid_d = 1'b1;
              wValid_d  = 1'b1;
              awAddr_d  = bk_waddr;
              wData_d   = bk_wdata;
              wStrb_d   = bk_wstrb;
              if (bk_rstart) begin
                rdQueued_d = 1'b1;
                arAddr_d   = bk_raddr;
              end
            end else if (bk_rstart) begin
              state_d   = RD_REQ;
              arValid_d = 1'b1;
              arAddr_d  = bk_raddr;
            end
          end
        end
        WR_REQ: begin
          if (awValid_q && axi_awready) awValid_d = 1'b0;
          if (wValid_q && axi_wready) wValid_d = 1'b0;
          if (!awPending && !wPending) begin
            state_d  = WR_RESP;
            bReady_d = 1'b1;
          end else if (timeoutHit) begin
            awValid_d = 1'b0;
            wValid_d  = 1'b0;
            fin_d     = 1'b1;
            err_d     = 1'b1;
          end
        end
        WR_RESP: begin
          if (axi_bvalid && bReady_q) begin
            bReady_d = 1'b0;
            fin_d    = 1'b1;
            err_d    = (axi_bresp != 2'b00);
          end else if (timeoutHit) begin
            bReady_d = 1'b0;
            fin_d    = 1'b1;
            err_d    = 1'b1;
          end
        end
        RD_REQ: begin
          if (arValid_q && axi_arready) begin
            arValid_d = 1'b0;
            state_d   = RD_RESP;
            rReady_d  = 1'b1;
          end else if (timeoutHit) begin
            arValid_d = 1'b0;
            fin_d     = 1'b1;
            err_d     = 1'b1;
            rCap_d    = '0;
          end
        end
        RD_RESP: begin
          if (axi_rvalid && rReady_q) begin
            rReady_d = 1'b0;
            fin_d    = 1'b1;
            err_d    = (axi_rresp != 2'b00);
            rCap_d   = axi_rdata;
          end else if (timeoutHit) begin
            rReady_d = 1'b0;
            fin_d    = 1'b1;
            err_d    = 1'b1;
            rCap_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d != IDLE) || rdQueued_d;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fin_q      <= 1'b0;
      err_q      <= 1'b0;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      bReady_q   <= 1'b0;
      arValid_q  <= 1'b0;
      rReady_q   <= 1'b0;
      awAddr_q   <= '0;
      wData_q    <= '0;
      wStrb_q    <= '0;
      arAddr_q   <= '0;
      rdQueued_q <= 1'b0;
      rCap_q     <= '0;
      rData_q    <= '0;
      wDone_q    <= 1'b0;
      wErr_q     <= 1'b0;
      rDone_q    <= 1'b0;
      rErr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fin_q      <= fin_d;
      err_q      <= err_d;
      awValid_q  <= awValid_d;
      wValid_q   <= wValid_d;
      bReady_q   <= bReady_d;
      arValid_q  <= arValid_d;
      rReady_q   <= rReady_d;
      awAddr_q   <= awAddr_d;
      wData_q    <= wData_d;
      wStrb_q    <= wStrb_d;
      arAddr_q   <= arAddr_d;
      rdQueued_q <= rdQueued_d;
      rCap_q     <= rCap_d;
      rData_q    <= rData_d;
      wDone_q    <= wDone_d;
      wErr_q     <= wErr_d;
      rDone_q    <= rDone_d;
      rErr_q     <= rErr_d;
      busy_q     <= busy_d;
    end
  end

  assign axi_awvalid = awValid_q;
  assign axi_awaddr  = awAddr_q;
  assign axi_wvalid  = wValid_q;
  assign axi_wdata   = wData_q;
  assign axi_wstrb   = wStrb_q;
  assign axi_bready  = bReady_q;
  assign axi_arvalid = arValid_q;
  assign axi_araddr  = arAddr_q;
  assign axi_rready  = rReady_q;
  assign bk_wdone    = wDone_q;
  assign bk_werr     = wErr_q;
  assign bk_rdata    = rData_q;
  assign bk_rdone    = rDone_q;
  assign bk_rerr     = rErr_q;
  assign bk_busy     = busy_q;

endmodule

// File: tb/tb_axilite_master_engine.sv
// Bench for axilite_master_engine: memory-backed AXI-Lite slave with programmable
// ready/valid delays, a vector table, corner-case sequences and a random run.
module tb_axilite_master_engine;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic aresetn = 1'b0;

  logic          axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0;
  logic          axi_bvalid = 1'b0, axi_rvalid = 1'b0;
  logic [1:0]    axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic [DW-1:0] axi_rdata = '0;

  logic          bk_wstart = 1'b0, bk_rstart = 1'b0;
  logic [AW-1:0] bk_waddr = '0, bk_raddr = '0;
  logic [DW-1:0] bk_wdata = '0;
  logic [SW-1:0] bk_wstrb = '0;
  logic          bk_wdone, bk_werr, bk_rdone, bk_rerr, bk_busy;
  logic [DW-1:0] bk_rdata;

  axilite_master_engine #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .axi_aclk(clock), .axi_aresetn(aresetn),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rready(axi_rready),
    .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
    .bk_wdone(bk_wdone), .bk_werr(bk_werr),
    .bk_rstart(bk_rstart), .bk_raddr(bk_raddr),
    .bk_rdata(bk_rdata), .bk_rdone(bk_rdone), .bk_rerr(bk_rerr), .bk_busy(bk_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs: cycles of valid (or ready) before the slave answers
  int         slvAwD = 0, slvWD = 0, slvBD = 0, slvArD = 0, slvRD = 0;
  logic [1:0] slvResp = 2'b00;
  logic [DW-1:0] slvMem [64];
  logic [DW-1:0] modelMem [64];

  int            awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
  bit            sAwSeen = 0, sWSeen = 0;
  logic [AW-1:0] sAwAddr = '0, sArAddr = '0;
  logic [DW-1:0] sWData = '0, sRData = '0;
  logic [SW-1:0] sWStrb = '0;

  // Slave decides its ready/valid at the falling edge; handshakes complete on the next rising edge
  always @(negedge clock) begin
    if (!aresetn) begin
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0; axi_rvalid = 0;
      awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0; sAwSeen = 0; sWSeen = 0;
    end else begin
      if (axi_awvalid) begin
        axi_awready = (awCnt == slvAwD);
        if (axi_awready) begin sAwAddr = axi_awaddr; sAwSeen = 1; end
        awCnt++;
      end else begin axi_awready = 0; awCnt = 0; end
      if (axi_wvalid) begin
        axi_wready = (wCnt == slvWD);
        if (axi_wready) begin sWData = axi_wdata; sWStrb = axi_wstrb; sWSeen = 1; end
        wCnt++;
      end else begin axi_wready = 0; wCnt = 0; end
      if (axi_bready) begin
        axi_bvalid = (bCnt == slvBD);
        if (axi_bvalid) begin
          axi_bresp = slvResp;
          if (sAwSeen && sWSeen) begin
            for (int b = 0; b < SW; b++)
              if (sWStrb[b]) slvMem[sAwAddr[7:2]][b*8 +: 8] = sWData[b*8 +: 8];
          end
          sAwSeen = 0; sWSeen = 0;
        end
        bCnt++;
      end else begin axi_bvalid = 0; bCnt = 0; end
      if (axi_arvalid) begin
        axi_arready = (arCnt == slvArD);
        if (axi_arready) begin sArAddr = axi_araddr; sRData = slvMem[axi_araddr[7:2]]; end
        arCnt++;
      end else begin axi_arready = 0; arCnt = 0; end
      if (axi_rready) begin
        axi_rvalid = (rCnt == slvRD);
        if (axi_rvalid) begin axi_rdata = sRData; axi_rresp = slvResp; end
        rCnt++;
      end else begin axi_rvalid = 0; rCnt = 0; end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setSlave(input int awD, input int wD, input int bD, input int arD, input int rD,
                          input logic [1:0] resp);
    slvAwD = awD; slvWD = wD; slvBD = bD; slvArD = arD; slvRD = rD; slvResp = resp;
  endtask

  // Drives the command for exactly one rising edge; returns #1 after that edge
  task automatic applyStimulus(input bit doW, input bit doR, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [SW-1:0] ws, input logic [AW-1:0] ra);
    @(negedge clock);
    bk_wstart = doW; bk_waddr = wa; bk_wdata = wd; bk_wstrb = ws;
    bk_rstart = doR; bk_raddr = ra;
    @(posedge clock); #1;
    bk_wstart = 0; bk_rstart = 0;
  endtask

  task automatic waitDone(input bit isWrite, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock);
      if (isWrite ? bk_wdone : bk_rdone) begin lat = k; break; end
    end
  endtask

  function automatic void modelWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++)
      if (s[b]) modelMem[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef struct {
    bit            isWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            awD, wD, bD, arD, rD;
    logic [1:0]    resp;
    int            expLat;
    bit            expErr;
    logic [DW-1:0] expData;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, kWd, kRd, kAr, awHigh, wHigh, arHigh, doneCnt, dataBad, busyEarly;
    logic errSeen, busyAfter;
    logic [DW-1:0] dataSeen;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 4, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 12'h020, 32'hA5A50001, 4'hF, 0, 3, 0, 0, 0, 2'b00, 7, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 12'h024, 32'hCAFEF00D, 4'hF, 3, 0, 0, 0, 0, 2'b00, 7, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 4, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 12'h020, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b00, 7, 1'b0, 32'hA5A50001};
    vecs[5]  = '{1'b1, 12'h018, 32'h11223344, 4'h5, 0, 0, 2, 0, 0, 2'b00, 6, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 12'h018, 32'h0,        4'h0, 0, 0, 0, 0, 2, 2'b00, 6, 1'b0, 32'h00220044};
    vecs[7]  = '{1'b0, 12'h040, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b10, 4, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 12'h044, 32'h01020304, 4'hF, 0, 0, 0, 0, 0, 2'b11, 4, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 12'h044, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 4, 1'b0, 32'h01020304};
    vecs[10] = '{1'b0, 12'h024, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 4, 1'b0, 32'hCAFEF00D};

    for (int i = 0; i < 64; i++) begin slvMem[i] = '0; modelMem[i] = '0; end

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset_ctrl",
                {54'd0, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready,
                 bk_wdone, bk_werr, bk_rdone, bk_rerr, bk_busy}, 64'd0);
    checkOutput("reset_rdata", 64'(bk_rdata), 64'd0);
    aresetn = 1'b1;

    // Zero-wait write, cycle by cycle
    setSlave(0, 0, 0, 0, 0, 2'b00);
    applyStimulus(1, 0, 12'h010, 32'hDEADBEEF, 4'hF, 12'h0);
    @(negedge clock);
    checkOutput("zw_t1_valids", {62'd0, axi_awvalid, axi_wvalid}, 64'd3);
    checkOutput("zw_t1_addr_data", {20'd0, axi_awaddr, axi_wdata}, {20'd0, 12'h010, 32'hDEADBEEF});
    @(negedge clock);
    checkOutput("zw_t2_bready_awvalid", {62'd0, axi_bready, axi_awvalid}, 64'd2);
    @(negedge clock);
    checkOutput("zw_t3_bready_done", {62'd0, axi_bready, bk_wdone}, 64'd0);
    @(negedge clock);
    checkOutput("zw_t4_done_err", {62'd0, bk_wdone, bk_werr}, 64'd2);
    modelWrite(12'h010, 32'hDEADBEEF, 4'hF);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      setSlave(vecs[i].awD, vecs[i].wD, vecs[i].bD, vecs[i].arD, vecs[i].rD, vecs[i].resp);
      applyStimulus(vecs[i].isWrite, !vecs[i].isWrite, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].addr);
      waitDone(vecs[i].isWrite, 40, lat);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].expLat));
      if (vecs[i].isWrite) begin
        checkOutput($sformatf("vec%0d_werr", i), 64'(bk_werr), 64'(vecs[i].expErr));
        checkOutput($sformatf("vec%0d_aw_w_fields", i), {16'd0, sAwAddr, sWStrb, sWData},
                    {16'd0, vecs[i].addr, vecs[i].strb, vecs[i].data});
        modelWrite(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        checkOutput($sformatf("vec%0d_rerr", i), 64'(bk_rerr), 64'(vecs[i].expErr));
        checkOutput($sformatf("vec%0d_rdata", i), 64'(bk_rdata), 64'(vecs[i].expData));
      end
    end

    // wready three cycles behind awready
    setSlave(0, 3, 0, 0, 0, 2'b00);
    applyStimulus(1, 0, 12'h020, 32'h5A5A0F0F, 4'hF, 12'h0);
    awHigh = 0; wHigh = 0; doneCnt = 0; dataBad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (axi_awvalid) awHigh++;
      if (axi_wvalid) begin
        wHigh++;
        if (axi_wdata !== 32'h5A5A0F0F || axi_wstrb !== 4'hF) dataBad++;
      end
      if (bk_wdone) doneCnt++;
    end
    checkOutput("wdelay_aw_cycles", 64'(awHigh), 64'd1);
    checkOutput("wdelay_w_cycles", 64'(wHigh), 64'd4);
    checkOutput("wdelay_data_stable", 64'(dataBad), 64'd0);
    checkOutput("wdelay_done_count", 64'(doneCnt), 64'd1);
    modelWrite(12'h020, 32'h5A5A0F0F, 4'hF);

    // Same-cycle write and read
    slvMem[13] = 32'h12345678; modelMem[13] = 32'h12345678;
    setSlave(0, 0, 0, 0, 0, 2'b00);
    applyStimulus(1, 1, 12'h030, 32'h0BADF00D, 4'hF, 12'h034);
    kWd = -1; kRd = -1; kAr = -1; busyEarly = 0; busyAfter = 1'bx; dataSeen = '0; errSeen = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (bk_wdone && kWd < 0) kWd = k;
      if (axi_arvalid && kAr < 0) kAr = k;
      if (kRd < 0 && !bk_rdone && !bk_busy) busyEarly++;
      if (kRd >= 0 && k == kRd + 1) busyAfter = bk_busy;
      if (bk_rdone && kRd < 0) begin kRd = k; dataSeen = bk_rdata; errSeen = bk_rerr; end
    end
    checkOutput("coll_wdone_cycle", 64'(kWd), 64'd4);
    checkOutput("coll_arvalid_cycle", 64'(kAr), 64'd5);
    checkOutput("coll_rdone_cycle", 64'(kRd), 64'd8);
    checkOutput("coll_rdata", 64'(dataSeen), 64'h12345678);
    checkOutput("coll_rerr", 64'(errSeen), 64'd0);
    checkOutput("coll_busy_gap", 64'(busyEarly), 64'd0);
    checkOutput("coll_busy_after", 64'(busyAfter), 64'd0);
    modelWrite(12'h030, 32'h0BADF00D, 4'hF);

    // Write times out on AW; the queued read still runs
    setSlave(1000, 0, 0, 0, 0, 2'b00);
    applyStimulus(1, 1, 12'h038, 32'h00000055, 4'hF, 12'h034);
    kWd = -1; kRd = -1; awHigh = 0; errSeen = 1'b0; busyAfter = 1'b1; dataSeen = '0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (axi_awvalid) awHigh++;
      if (bk_wdone && kWd < 0) begin kWd = k; errSeen = bk_werr; end
      if (bk_rdone && kRd < 0) begin kRd = k; dataSeen = bk_rdata; busyAfter = bk_rerr; end
    end
    checkOutput("wto_aw_cycles", 64'(awHigh), 64'd8);
    checkOutput("wto_wdone_cycle", 64'(kWd), 64'd10);
    checkOutput("wto_werr", 64'(errSeen), 64'd1);
    checkOutput("wto_queued_rdone_cycle", 64'(kRd), 64'd14);
    checkOutput("wto_queued_rdata", 64'(dataSeen), 64'h12345678);
    checkOutput("wto_queued_rerr", 64'(busyAfter), 64'd0);

    // Read times out on AR, then a normal read
    setSlave(0, 0, 0, 1000, 0, 2'b00);
    applyStimulus(0, 1, 12'h0, 32'h0, 4'h0, 12'h040);
    kRd = -1; arHigh = 0; errSeen = 1'b0; dataSeen = 32'hFFFFFFFF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (axi_arvalid) arHigh++;
      if (bk_rdone && kRd < 0) begin kRd = k; errSeen = bk_rerr; dataSeen = bk_rdata; end
    end
    checkOutput("rto_ar_cycles", 64'(arHigh), 64'd8);
    checkOutput("rto_rdone_cycle", 64'(kRd), 64'd10);
    checkOutput("rto_rerr", 64'(errSeen), 64'd1);
    checkOutput("rto_rdata", 64'(dataSeen), 64'd0);
    setSlave(0, 0, 0, 0, 0, 2'b00);
    applyStimulus(0, 1, 12'h0, 32'h0, 4'h0, 12'h010);
    waitDone(0, 40, lat);
    checkOutput("rto_next_latency", 64'(lat), 64'd4);
    checkOutput("rto_next_rdata_err", {31'd0, bk_rerr, bk_rdata}, {32'd0, modelMem[4]});

    // Reset while waiting in WR_RESP
    setSlave(0, 0, 1000, 0, 0, 2'b00);
    applyStimulus(1, 0, 12'h050, 32'h00000077, 4'hF, 12'h0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_in_wr_resp", 64'(axi_bready), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("rst_async_ctrl",
                {54'd0, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready,
                 bk_wdone, bk_werr, bk_rdone, bk_rerr, bk_busy}, 64'd0);
    checkOutput("rst_async_rdata", 64'(bk_rdata), 64'd0);
    doneCnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bk_wdone) doneCnt++;
    end
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bk_wdone) doneCnt++;
    end
    checkOutput("rst_no_wdone", 64'(doneCnt), 64'd0);
    setSlave(0, 0, 0, 0, 0, 2'b00);
    applyStimulus(1, 0, 12'h050, 32'h00000099, 4'hF, 12'h0);
    waitDone(1, 40, lat);
    checkOutput("rst_after_wlat", 64'(lat), 64'd4);
    checkOutput("rst_after_werr", 64'(bk_werr), 64'd0);
    modelWrite(12'h050, 32'h00000099, 4'hF);
    applyStimulus(0, 1, 12'h0, 32'h0, 4'h0, 12'h050);
    waitDone(0, 40, lat);
    checkOutput("rst_after_rdata", 64'(bk_rdata), 64'h99);

    // Random traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      bit            isW;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      int            dAw, dW, dB, dAr, dR, expLat;
      logic [1:0]    r;
      isW = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 63)) << 2;
      d   = $urandom;
      s   = SW'($urandom);
      dAw = $urandom_range(0, 4); dW = $urandom_range(0, 4); dB = $urandom_range(0, 4);
      dAr = $urandom_range(0, 4); dR = $urandom_range(0, 4);
      r   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      setSlave(dAw, dW, dB, dAr, dR, r);
      applyStimulus(isW, !isW, a, d, s, a);
      if (isW) begin
        expLat = 1 + maxInt(dAw, dW) + 1 + dB + 2;
        waitDone(1, 40, lat);
        checkOutput($sformatf("rand%0d_wlat", i), 64'(lat), 64'(expLat));
        checkOutput($sformatf("rand%0d_werr", i), 64'(bk_werr), 64'(r != 2'b00));
        modelWrite(a, d, s);
      end else begin
        expLat = 1 + dAr + 1 + dR + 2;
        waitDone(0, 40, lat);
        checkOutput($sformatf("rand%0d_rlat", i), 64'(lat), 64'(expLat));
        checkOutput($sformatf("rand%0d_rerr", i), 64'(bk_rerr), 64'(r != 2'b00));
        checkOutput($sformatf("rand%0d_rdata", i), 64'(bk_rdata), 64'(modelMem[a[7:2]]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axilite_master_engine.md
Name: axilite_master_engine

Overview:
- Parametrised AXI-Lite master that converts single-pulse backend read/write commands (bk_*) into full AXI-Lite transactions, including the B and R response channels with error reporting.
- Adds configurable address/data width, independent AW/W completion, a same-cycle read/write collision queue and a per-transaction timeout.
- Sits between local control logic (register sequencers, test drivers) and any AXI-Lite slave in the fabric.

Parameters:
- ADDR_W, 12, AXI/backend address width.
- DATA_W, 32, data width (32 or 64); strobe width is DATA_W/8.
- TIMEOUT_CYC, 256, cycles a transaction may wait on the slave before abort; 0 disables the timeout.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- axi_awvalid/axi_awaddr  out  1/ADDR_W  write address channel
- axi_awready  in  1
- axi_wvalid/axi_wdata/axi_wstrb  out  1/DATA_W/DATA_W/8  write data channel
- axi_wready  in  1
- axi_bvalid/axi_bresp  in  1/2  write response; axi_bready out 1
- axi_arvalid/axi_araddr  out  1/ADDR_W; axi_arready in 1
- axi_rvalid/axi_rdata/axi_rresp  in  1/DATA_W/2; axi_rready out 1
- bk_wstart  in  1  write command pulse; bk_waddr/bk_wdata/bk_wstrb  in  ADDR_W/DATA_W/DATA_W/8
- bk_wdone/bk_werr  out  1/1  write completion pulse / error flag, valid with done
- bk_rstart  in  1  read command pulse; bk_raddr  in  ADDR_W
- bk_rdata/bk_rdone/bk_rerr  out  DATA_W/1/1  read data, completion pulse, error flag
- bk_busy  out  1  high while any command is in flight or queued

Behaviour:
- One clock (axi_aclk). Reset is asynchronous, active-low (axi_aresetn). Reset drives all outputs to 0 and the FSM to IDLE, and clears any queued read. Reset mid-transaction aborts it; no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- Command acceptance:
  - Commands are accepted only in IDLE with bk_busy=0; starts while busy are ignored.
  - Command fields are captured on the start cycle.
- Collision: bk_wstart and bk_rstart in the same cycle → the write executes first. The read address is queued and RD_REQ is entered on the cycle after bk_wdone. bk_busy stays high throughout.
- IDLE→WR_REQ on accepted write. axi_awvalid and axi_wvalid rise on the next cycle (T+1).
- WR_REQ:
  - awvalid drops after its own awready handshake; wvalid drops after its own wready handshake. The two handshakes may occur in either order or together.
  - Addr/data/strb stay stable until their own handshake.
  - When both handshakes are complete → WR_RESP.
- WR_RESP: axi_bready=1. On bvalid&bready: bready drops, then the next cycle pulses bk_wdone for 1 cycle with bk_werr=(bresp!=0) → IDLE (or RD_REQ if a read is queued).
- RD_REQ: axi_arvalid=1 until arready → RD_RESP.
- RD_RESP: axi_rready=1. On rvalid&rready: capture rdata. Next cycle: bk_rdone pulse, bk_rerr=(rresp!=0), bk_rdata valid → IDLE.
- bk_rdata holds its value until the next read completes.
- Minimum latency with a zero-wait slave: write start T → done T+4; read start T → done T+4.
- Timeout:
  - A counter is cleared on state entry and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - At count == TIMEOUT_CYC-1 without the awaited handshake: deassert all valid/ready outputs, then pulse done next cycle with err=1.
  - On a read timeout bk_rdata=0.
  - A queued read still executes after a write timeout.
- Backpressure of any length up to the timeout is legal; valid signals never drop before their handshake.

Test Plan:
- Zero-wait slave, write addr 0x010, data 0xDEADBEEF, strb 0xF → AW/W seen at T+1, bready at T+2, bk_wdone at T+4, bk_werr=0.
- wready delayed 3 cycles after awready; write 0x020 → awvalid drops after 1 cycle, wvalid held 4 cycles with stable data, single bk_wdone.
- Simultaneous bk_wstart (0x030) and bk_rstart (0x034); slave returns 0x12345678 → write completes first, arvalid rises the cycle after bk_wdone, bk_rdata=0x12345678, bk_busy low only after bk_rdone.
- Read of 0x040 with slave rresp=2'b10 → bk_rdone with bk_rerr=1; write with bresp=2'b11 → bk_werr=1.
- TIMEOUT_CYC=8, slave never asserts arready → arvalid drops after 8 cycles, bk_rdone with bk_rerr=1 and bk_rdata=0; a following read to a responsive slave succeeds.
- Assert axi_aresetn low during WR_RESP → all outputs 0 immediately, no bk_wdone; bk_wstart after release is accepted normally.
